// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the burst SRAM controller.
//   state_e     : controller FSM states
//   WAIT_CNT_W  : width of the per-beat access-cycle counter
//   MAX_BE_W    : widest byte-enable vector the mask helper supports
//   be_to_mask  : expands byte enables into a per-bit data mask
package sram_ctrl_pkg;

    localparam int WAIT_CNT_W = 4;
    localparam int MAX_BE_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_ACCESS,
        ST_RD_TURN
    } state_e;

    // Each enable bit covers one byte lane; callers truncate to their width.
    function automatic logic [MAX_BE_W*8-1:0] be_to_mask(input logic [MAX_BE_W-1:0] be);
        logic [MAX_BE_W*8-1:0] m;
        for (int i = 0; i < MAX_BE_W; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_data_io.sv
// Data-bus front end for the SRAM controller.
//   drive_en_i   : drive the latched write word onto sram_data_io
//   load_i       : latch wr_data_i as the next write word
//   capture_i    : sample sram_data_io (masked by mask_i) into rd_data_o
//   sram_data_io : bidirectional SRAM data bus
module sram_data_io #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              drive_en_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              capture_i,
    input  logic [DATA_W-1:0] mask_i,
    output logic [DATA_W-1:0] rd_data_o,
    inout  wire  [DATA_W-1:0] sram_data_io
);

    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    assign sram_data_io = drive_en_i ? wdata_q : {DATA_W{1'bz}};
    assign rd_data_o    = rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (load_i) begin
                wdata_q <= wr_data_i;
            end
            if (capture_i) begin
                rdata_q <= sram_data_io & mask_i;
            end
        end
    end

endmodule

// File: rtl/sram_burst_controller.sv
// Burst controller for an external asynchronous SRAM.
// Host side: cmd_* (valid/ready command), wr_* (valid/ready write beats),
//            rd_valid_o/rd_data_o (one pulse per read beat), busy_o.
// SRAM side: sram_addr_o, sram_data_io (bidirectional), active-low
//            sram_ce_n_o / sram_oe_n_o / sram_we_n_o / sram_be_n_o.
// Strobes are decoded from the state register only, so no host input
// reaches an SRAM pin combinationally.
module sram_burst_controller
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int LEN_W       = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [LEN_W-1:0]    cmd_len_i,
    input  logic [DATA_W/8-1:0] cmd_be_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [DATA_W-1:0]   wr_data_i,
    output logic                rd_valid_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   sram_addr_o,
    inout  wire  [DATA_W-1:0]   sram_data_io,
    output logic                sram_ce_n_o,
    output logic                sram_oe_n_o,
    output logic                sram_we_n_o,
    output logic [DATA_W/8-1:0] sram_be_n_o
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in the range 1..15");
    end
    if ((DATA_W % 8) != 0 || BE_W > MAX_BE_W || BE_W < 1) begin : g_bad_data_w
        $error("DATA_W must be a non-zero multiple of 8 and at most 128");
    end

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic                  ready_q;
    logic                  rd_valid_q;
    logic                  wr_load;
    logic                  capture;
    logic                  drive_en;
    logic                  access;
    logic [DATA_W-1:0]     byte_mask;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        be_d    = be_q;
        wr_load = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    addr_d  = cmd_addr_i;
                    cnt_d   = cmd_len_i;
                    be_d    = cmd_be_i;
                    wait_d  = WAIT_LOAD;
                    state_d = cmd_we_i ? ST_WR_DATA : ST_RD_ACCESS;
                end
            end
            ST_WR_DATA: begin
                if (wr_valid_i) begin
                    wr_load = 1'b1;
                    wait_d  = WAIT_LOAD;
                    state_d = ST_WR_PULSE;
                end
            end
            ST_WR_PULSE: begin
                if (wait_q == '0) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_WR_HOLD: begin
                if (cnt_q != '0) begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = ST_WR_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ACCESS: begin
                if (wait_q == '0) begin
                    capture = 1'b1;
                    if (cnt_q != '0) begin
                        // Next beat starts immediately with a fresh access window.
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                        wait_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_RD_TURN;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_RD_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            be_q       <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            be_q       <= be_d;
            // Held low through reset so the host sees ready only after the first edge.
            ready_q    <= (state_d == ST_IDLE);
            rd_valid_q <= capture;
        end
    end

    assign drive_en = (state_q == ST_WR_PULSE) || (state_q == ST_WR_HOLD);
    assign access   = drive_en || (state_q == ST_RD_ACCESS);

    assign cmd_ready_o = ready_q;
    assign wr_ready_o  = (state_q == ST_WR_DATA);
    assign busy_o      = (state_q != ST_IDLE);
    assign rd_valid_o  = rd_valid_q;
    assign sram_addr_o = addr_q;
    assign sram_ce_n_o = ~access;
    assign sram_we_n_o = ~(state_q == ST_WR_PULSE);
    assign sram_oe_n_o = ~(state_q == ST_RD_ACCESS);
    assign sram_be_n_o = access ? ~be_q : {BE_W{1'b1}};

    assign byte_mask = DATA_W'(be_to_mask(MAX_BE_W'(be_q)));

    sram_data_io #(
        .DATA_W(DATA_W)
    ) u_io (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .drive_en_i  (drive_en),
        .load_i      (wr_load),
        .wr_data_i   (wr_data_i),
        .capture_i   (capture),
        .mask_i      (byte_mask),
        .rd_data_o   (rd_data_o),
        .sram_data_io(sram_data_io)
    );

endmodule
